// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle, with a one-cycle
//               register-file write when the result is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int DATA_N = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_N-1:0] rs1_data_i,
  input  logic [DATA_N-1:0] rs2_data_i,
  input  logic [4:0]        rd_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_wren_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_N-1:0] result_o
);

  localparam int               CNT_W    = $clog2(DATA_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched operation and iteration state. hi/lo are shared: for multiply
  // they form the 2*DATA_N accumulator (lo starts as the multiplier), for
  // divide hi is the partial remainder and lo shifts dividend out / quotient in.
  logic [2:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_N-1:0] hi, lo, opd;
  logic              neg_q, neg_r;

  // Operand decode at accept time
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [DATA_N-1:0] a_mag, b_mag;
  logic              is_div, div_zero, div_ovf;

  // Per-iteration datapath
  logic [DATA_N:0]   mul_sum;
  logic [DATA_N:0]   div_shift;
  logic [DATA_N-1:0] div_diff;
  logic              div_ge;

  // Sign-corrected final result
  logic [2*DATA_N-1:0] prod, prod_fix;
  logic [DATA_N-1:0]   quo_fix, rem_fix, final_val;

  assign busy_o    = (state != IDLE);
  assign rd_wren_o = done_o;

  // Decode signedness, magnitudes and the divide special cases from the inputs
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & rs1_data_i[DATA_N-1];
    b_neg    = b_signed & rs2_data_i[DATA_N-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    is_div   = funct3_i[2];
    div_zero = is_div & (rs2_data_i == '0);
    div_ovf  = is_div & ~funct3_i[0]
             & (rs1_data_i == {1'b1, {(DATA_N-1){1'b0}}})
             & (rs2_data_i == {DATA_N{1'b1}});
  end

  // One shift-add step and one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(DATA_N+1){1'b0}});
    div_shift = {hi, lo[DATA_N-1]};
    div_ge    = (div_shift >= {1'b0, opd});
    // When div_ge holds the true difference is below opd, so DATA_N bits suffice
    div_diff  = div_shift[DATA_N-1:0] - opd;
  end

  // Apply the sign correction and pick the half/quotient/remainder for the op
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo : lo;
    rem_fix  = neg_r ? -hi : hi;
    case (op)
      3'b000:                 final_val = prod_fix[DATA_N-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_fix[2*DATA_N-1:DATA_N];
      3'b100, 3'b101:         final_val = quo_fix;
      default:                final_val = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; divide special cases bypass iteration entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = (div_zero | div_ovf) ? DONE : CALC;
      CALC: if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result/write-pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op        <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opd       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      done_o    <= 1'b0;
      rd_addr_o <= '0;
      result_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op        <= funct3_i;
            rd_addr_o <= rd_addr_i;
            cnt       <= '0;
            if (div_zero) begin
              // quotient all ones, remainder is the raw dividend
              hi    <= rs1_data_i;
              lo    <= {DATA_N{1'b1}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              hi    <= '0;
              lo    <= {1'b1, {(DATA_N-1){1'b0}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (is_div) begin
              hi    <= '0;
              lo    <= a_mag;
              opd   <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end else begin
              hi    <= '0;
              lo    <= b_mag;
              opd   <= a_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op[2]) begin
            hi <= div_ge ? div_diff : div_shift[DATA_N-1:0];
            lo <= {lo[DATA_N-2:0], div_ge};
          end else begin
            hi <= mul_sum[DATA_N:1];
            lo <= {mul_sum[0], lo[DATA_N-1:1]};
          end
        end
        DONE: begin
          result_o <= final_val;
          done_o   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed vector table,
//               randomized ops against a 64-bit arithmetic reference, and
//               hand-written sequences for held start and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, done_o, rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] result_o;

  int n_pass = 0;
  int n_total = 0;

  muldiv_unit #(.DATA_N(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_wren_o  (rd_wren_o),
    .rd_addr_o  (rd_addr_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;           r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  // Issue one op, scramble inputs after accept, then check timing and result
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int exp_lat, input logic [31:0] exp_res,
                        input string tag);
    int k;
    @(negedge clk);
    funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    funct3_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom);
    k = 1;
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    while (!done_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
    check({tag, "_wren"}, 32'(rd_wren_o), 32'd1);
    check({tag, "_busy_low"}, 32'(busy_o), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_hold"}, result_o, exp_res);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k, writes, last, pulses;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int lat;

    tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 34};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 34};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34};
    tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        34};
    tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         34};
    tbl[8]  = '{3'd5, 32'h0000_1234, 32'h0,         5'd9,  32'hFFFF_FFFF, 2};
    tbl[9]  = '{3'd6, 32'h0000_1234, 32'h0,         5'd10, 32'h0000_1234, 2};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 2};
    tbl[12] = '{3'd4, 32'h0000_0055, 32'h0,         5'd31, 32'hFFFF_FFFF, 2};
    tbl[13] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        34};

    rst_i = 1'b1; start_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_wren", 32'(rd_wren_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_rd", 32'(rd_addr_o), 32'd0);

    // Directed vectors
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].lat, tbl[i].exp, $sformatf("vec%0d", i));

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 34;
      run_op(f3, a, b, 5'($urandom), lat, model(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3));
    end

    // start held high: one write per 34 cycles, operands garbage except at accept
    @(negedge clk);
    funct3_i = 3'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd6; rd_addr_i = 5'd9; start_i = 1'b1;
    k = 0; writes = 0; last = 0;
    while (writes < 3 && k < 200) begin
      @(negedge clk);
      k++;
      if (done_o) begin
        writes++;
        check($sformatf("held_res%0d", writes), result_o, 32'd30);
        check($sformatf("held_gap%0d", writes), 32'(k - last), 32'd34);
        last = k;
        rs1_data_i = 32'd5; rs2_data_i = 32'd6;
        if (writes == 3) start_i = 1'b0;
      end else begin
        rs1_data_i = $urandom; rs2_data_i = $urandom;
      end
    end
    start_i = 1'b0;
    check("held_writes", 32'(writes), 32'd3);
    @(negedge clk);
    check("held_idle", 32'(busy_o), 32'd0);

    // Reset at CALC cycle 10 discards the op
    @(negedge clk);
    funct3_i = 3'd0; rs1_data_i = 32'h1234; rs2_data_i = 32'h55; rd_addr_i = 5'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_wren_o) pulses++;
      @(negedge clk);
    end
    check("rst_no_write", 32'(pulses), 32'd0);

    // Reset has priority over start
    funct3_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9; start_i = 1'b1; rst_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; rst_i = 1'b0;
    check("rst_prio_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("rst_prio_idle", 32'(busy_o), 32'd0);

    run_op(3'd0, 32'd3, 32'd4, 5'd13, 34, 32'd12, "post_rst_mul");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
